// File: rtl/mac_result_collector.sv
// Result collector behind the MAC block: captures real results from C into a small FIFO,
// presents them on a valid/ready stream and returns credit-based issue_ready upstream.
module mac_result_collector #(
    parameter int INT_WIDTH   = 32,
    parameter int MAC_LATENCY = 1,
    parameter int DEPTH       = 4,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_last,
    input  logic                     acc_mode,
    output logic                     issue_ready,
    input  logic [INT_WIDTH-1:0]     mac_c,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [INT_WIDTH-1:0]     res_data,
    output logic [TAG_WIDTH-1:0]     res_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = CW + 3;

    function automatic logic [2:0] ones_count(input logic [MAC_LATENCY-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < MAC_LATENCY; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    logic [MAC_LATENCY-1:0] pipe_r;
    logic [INT_WIDTH-1:0]   mem_data_r [DEPTH];
    logic [TAG_WIDTH-1:0]   mem_tag_r  [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic                   overflow_r;
    logic                   res_valid_r;
    logic [INT_WIDTH-1:0]   res_data_r;
    logic [TAG_WIDTH-1:0]   res_tag_r;

    logic                   cap_s;
    logic                   push_s;
    logic                   wr_en_s;
    logic                   pop_s;
    logic [2:0]             inflight_s;
    logic [AW-1:0]          rd_ptr_n_s;
    logic [CW-1:0]          count_n_s;
    logic [INT_WIDTH-1:0]   head_data_s;
    logic [TAG_WIDTH-1:0]   head_tag_s;

    assign cap_s       = issue_valid & (~acc_mode | issue_last);
    assign push_s      = pipe_r[MAC_LATENCY-1];
    assign inflight_s  = ones_count(pipe_r);
    // Credits come from registered state only, so a pop frees a slot one cycle later.
    assign issue_ready = ({3'b000, count_r} + {{(FW-3){1'b0}}, inflight_s}) < FW'(DEPTH);

    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_tag   = res_tag_r;
    assign count     = count_r;
    assign overflow  = overflow_r;

    // FIFO control and next head selection (a push can land directly in the head slot).
    always_comb begin
        wr_en_s   = push_s & (count_r != CW'(DEPTH));
        pop_s     = res_valid_r & res_ready;
        if (pop_s) begin
            rd_ptr_n_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end
        count_n_s = count_r + {{AW{1'b0}}, wr_en_s} - {{AW{1'b0}}, pop_s};
        if (wr_en_s && (wr_ptr_r == rd_ptr_n_s)) begin
            head_data_s = mac_c;
            head_tag_s  = tag_r;
        end else begin
            head_data_s = mem_data_r[rd_ptr_n_s];
            head_tag_s  = mem_tag_r[rd_ptr_n_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_data_r[wr_ptr_r] <= mac_c;
            mem_tag_r[wr_ptr_r]  <= tag_r;
        end
    end

    // Delay line, pointers, tag counter, sticky overflow and registered head outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_r      <= {MAC_LATENCY{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            tag_r       <= {TAG_WIDTH{1'b0}};
            overflow_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {INT_WIDTH{1'b0}};
            res_tag_r   <= {TAG_WIDTH{1'b0}};
        end else begin
            pipe_r[0] <= cap_s;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
            overflow_r <= overflow_r | (cap_s & ~issue_ready);
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                tag_r    <= tag_r + TAG_WIDTH'(1);
            end
            rd_ptr_r    <= rd_ptr_n_s;
            count_r     <= count_n_s;
            res_valid_r <= (count_n_s != {CW{1'b0}});
            if (count_n_s != {CW{1'b0}}) begin
                res_data_r <= head_data_s;
                res_tag_r  <= head_tag_s;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_collector.sv
// Scoreboard bench for mac_result_collector: expected results are queued at issue time
// and compared when the DUT hands them out on the result stream.
module tb_mac_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_last = 1'b0;
    logic        acc_mode = 1'b0;
    logic        issue_ready;
    logic [31:0] mac_c = 32'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [7:0]  res_tag;
    logic [2:0]  count;
    logic        overflow;

    int          n_vec = 0;
    int          n_err = 0;
    logic [39:0] sb_q[$];
    logic [7:0]  tag_m = 8'd0;
    logic [31:0] c_pend = 32'h0;
    logic        t1_mon = 1'b0;

    mac_result_collector #(
        .INT_WIDTH(32), .MAC_LATENCY(1), .DEPTH(4), .TAG_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
        .acc_mode(acc_mode), .issue_ready(issue_ready), .mac_c(mac_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus: mac_c carries the value promised by the previous issue.
    task automatic step(input logic iv, input logic il, input logic am,
                        input logic [31:0] c, input logic keep);
        @(posedge clk);
        #2;
        mac_c       = c_pend;
        issue_valid = iv;
        issue_last  = il;
        acc_mode    = am;
        c_pend      = c;
        if (iv && (!am || il) && keep) begin
            sb_q.push_back({tag_m, c});
            tag_m = tag_m + 8'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) idle(1);
        idle(2);
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic reset_dut();
        issue_valid = 1'b0;
        rst = 1'b0;
        sb_q.delete();
        tag_m = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Result monitor: a handshake seen at negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_nonempty", 64'(sb_q.size()), 64'd1);
            end else begin
                logic [39:0] e;
                e = sb_q.pop_front();
                check_eq("res_data", 64'(res_data), 64'(e[31:0]));
                check_eq("res_tag", 64'(res_tag), 64'(e[39:32]));
            end
        end
        if (rst && t1_mon) check_eq("t1_count_le1", 64'(count <= 3'd1), 64'd1);
    end

    initial begin
        reset_dut();
        check_eq("rst_valid", 64'(res_valid), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_ready", 64'(issue_ready), 64'd1);
        check_eq("rst_data", 64'(res_data), 64'd0);
        check_eq("rst_tag", 64'(res_tag), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);

        // Three back-to-back multiply-only results.
        res_ready = 1'b1;
        t1_mon = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h10, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h20, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h30, 1'b1);
        drain();
        t1_mon = 1'b0;

        // Accumulate group: only the final value is a result.
        reset_dut();
        res_ready = 1'b1;
        for (int i = 1; i <= 5; i++) step(1'b1, (i == 5), 1'b1, 32'(3 * i), 1'b1);
        drain();

        // Credits with a stalled consumer.
        reset_dut();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h100 + 32'(i), 1'b1);
        idle(1);
        @(negedge clk);
        check_eq("t3_ready_inflight", 64'(issue_ready), 64'd0);
        check_eq("t3_count3", 64'(count), 64'd3);
        idle(1);
        @(negedge clk);
        check_eq("t3_count4", 64'(count), 64'd4);
        idle(1);
        res_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_ready_same_cycle", 64'(issue_ready), 64'd0);
        idle(1);
        res_ready = 1'b0;
        @(negedge clk);
        check_eq("t3_ready_back", 64'(issue_ready), 64'd1);
        check_eq("t3_count_after_pop", 64'(count), 64'd3);
        drain();

        // Forced issue into a full FIFO.
        reset_dut();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'hA00 + 32'(i), 1'b1);
        idle(2);
        @(negedge clk);
        check_eq("t4_full", 64'(count), 64'd4);
        check_eq("t4_ready_low", 64'(issue_ready), 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'hBADBAD, 1'b0);
        idle(3);
        @(negedge clk);
        check_eq("t4_ovf", 64'(overflow), 64'd1);
        check_eq("t4_count_kept", 64'(count), 64'd4);
        check_eq("t4_head", 64'(res_data), 64'hA00);
        drain();
        check_eq("t4_ovf_sticky", 64'(overflow), 64'd1);
        check_eq("t4_empty_valid", 64'(res_valid), 64'd0);

        // Long stream: tag wraps past 255.
        reset_dut();
        res_ready = 1'b1;
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, 32'(i * 7 + 5), 1'b1);
        drain();
        check_eq("t5_tag_model", 64'(tag_m), 64'd44);

        // Reset with buffered and in-flight results.
        reset_dut();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'hC0 + 32'(i), 1'b1);
        @(posedge clk);
        #2;
        issue_valid = 1'b0;
        check_eq("t6_pre_count", 64'(count), 64'd2);
        rst = 1'b0;
        #1;
        check_eq("t6_rst_valid", 64'(res_valid), 64'd0);
        check_eq("t6_rst_count", 64'(count), 64'd0);
        check_eq("t6_rst_ready", 64'(issue_ready), 64'd1);
        sb_q.delete();
        tag_m = 8'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        res_ready = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h5A5A, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
